icache_prog_buffer: RTL and testbench

- Instruction memory directly upstream of the TPU control unit.
- The host streams a program of 54-bit instruction words into it over a valid/ready handshake.
- The control unit reads it through a 1-cycle-latency synchronous read port.
- Generates finish_flag when a read falls outside the loaded program, or when no program is loaded, so the control unit substitutes its finish instruction.

---
 rtl/icache_prog_buffer.sv | 127 ++++++++++++
 tb/tb_icache_prog_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_prog_buffer.sv
// Instruction program buffer: host load over valid/ready, 1-cycle synchronous read with finish detection.
// Optional ICACHE_PARITY_EN adds a per-word even-parity bit and a sticky parity_err output.
module icache_prog_buffer #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 54
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_wr_last,
  input  logic [ADDR_W-1:0] icache_rd_ctrl_addr,
  input  logic              icache_rd_ctrl_en,
  output logic [DATA_W-1:0] icache_rd_ctrl_data,
  output logic              finish_flag,
  output logic              prog_loaded,
  output logic [ADDR_W:0]   prog_len
`ifdef ICACHE_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  typedef enum logic [1:0] {IDLE, LOADING, LOADED} state_t;

  localparam logic [ADDR_W-1:0] WPTR_MAX = ADDR_W'(DEPTH - 1);

`ifdef ICACHE_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic              wr_fire;
  logic              wr_end;
  logic              rd_hit;
  logic              rd_ok;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  mem [DEPTH];

  assign wr_fire = host_wr_valid && host_wr_ready;
  // A full buffer terminates the load exactly like an explicit last word.
  assign wr_end  = host_wr_last || (wptr == WPTR_MAX);
  assign rd_word = mem[icache_rd_ctrl_addr];
  assign rd_hit  = prog_loaded && ({1'b0, icache_rd_ctrl_addr} < prog_len);

`ifdef ICACHE_PARITY_EN
  assign wr_word = {^host_wr_data, host_wr_data};
  assign rd_ok   = ~^rd_word;
`else
  assign wr_word = host_wr_data;
  assign rd_ok   = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    host_wr_ready = 1'b0;
    if (load_start) begin
      state_nxt = LOADING;
    end else begin
      case (state)
        LOADING: begin
          host_wr_ready = 1'b1;
          if (host_wr_valid && wr_end) state_nxt = LOADED;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr                <= '0;
      prog_len            <= '0;
      prog_loaded         <= 1'b0;
      finish_flag         <= 1'b0;
      icache_rd_ctrl_data <= '0;
`ifdef ICACHE_PARITY_EN
      parity_err          <= 1'b0;
`endif
    end else begin
      if (load_start) begin
        wptr        <= '0;
        prog_len    <= '0;
        prog_loaded <= 1'b0;
        finish_flag <= 1'b0;
`ifdef ICACHE_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end else if (wr_fire) begin
        wptr <= wptr + ADDR_W'(1);
        if (wr_end) begin
          prog_len    <= {1'b0, wptr} + (ADDR_W+1)'(1);
          prog_loaded <= 1'b1;
        end
      end
      // Range check uses pre-edge prog_loaded/prog_len; load_start clear wins over a new finish.
      if (icache_rd_ctrl_en) begin
        if (rd_hit && rd_ok) begin
          icache_rd_ctrl_data <= rd_word[DATA_W-1:0];
        end else begin
          icache_rd_ctrl_data <= '0;
          if (!load_start) finish_flag <= 1'b1;
`ifdef ICACHE_PARITY_EN
          if (!load_start && rd_hit) parity_err <= 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_prog_buffer.sv
// Directed, table-driven bench for icache_prog_buffer; covers ICACHE_PARITY_EN when defined.
module tb_icache_prog_buffer;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 54;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [DATA_W-1:0] host_wr_data;
  logic              host_wr_last;
  logic [ADDR_W-1:0] icache_rd_ctrl_addr;
  logic              icache_rd_ctrl_en;
  logic [DATA_W-1:0] icache_rd_ctrl_data;
  logic              finish_flag;
  logic              prog_loaded;
  logic [ADDR_W:0]   prog_len;
`ifdef ICACHE_PARITY_EN
  logic              parity_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  icache_prog_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .load_start          (load_start),
    .host_wr_valid       (host_wr_valid),
    .host_wr_ready       (host_wr_ready),
    .host_wr_data        (host_wr_data),
    .host_wr_last        (host_wr_last),
    .icache_rd_ctrl_addr (icache_rd_ctrl_addr),
    .icache_rd_ctrl_en   (icache_rd_ctrl_en),
    .icache_rd_ctrl_data (icache_rd_ctrl_data),
    .finish_flag         (finish_flag),
    .prog_loaded         (prog_loaded),
    .prog_len            (prog_len)
`ifdef ICACHE_PARITY_EN
    ,
    .parity_err          (parity_err)
`endif
  );

  typedef struct {
    logic              ls;
    logic              vld;
    logic [DATA_W-1:0] dat;
    logic              lst;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic              e_rdy;
    logic [DATA_W-1:0] e_data;
    logic              e_fin;
    logic              e_ldd;
    logic [ADDR_W:0]   e_len;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ls, input logic vld, input logic [DATA_W-1:0] dat,
                              input logic lst, input logic ren, input logic [ADDR_W-1:0] addr,
                              input logic e_rdy, input logic [DATA_W-1:0] e_data,
                              input logic e_fin, input logic e_ldd, input logic [ADDR_W:0] e_len);
    vec_t v;
    v.ls = ls; v.vld = vld; v.dat = dat; v.lst = lst; v.ren = ren; v.addr = addr;
    v.e_rdy = e_rdy; v.e_data = e_data; v.e_fin = e_fin; v.e_ldd = e_ldd; v.e_len = e_len;
    vecs.push_back(v);
  endfunction

  function automatic logic [DATA_W-1:0] fill_word(input int unsigned i);
    return {24'h5A5A5A, 30'(i * 7 + 3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ls, input logic vld, input logic [DATA_W-1:0] dat,
                       input logic lst, input logic ren, input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    load_start          = ls;
    host_wr_valid       = vld;
    host_wr_data        = dat;
    host_wr_last        = lst;
    icache_rd_ctrl_en   = ren;
    icache_rd_ctrl_addr = addr;
  endtask

  task automatic check_out(input string tag, input logic [DATA_W-1:0] e_data, input logic e_fin,
                           input logic e_ldd, input logic [ADDR_W:0] e_len);
    check({tag, ".data"}, 64'(icache_rd_ctrl_data), 64'(e_data));
    check({tag, ".finish"}, 64'(finish_flag), 64'(e_fin));
    check({tag, ".loaded"}, 64'(prog_loaded), 64'(e_ldd));
    check({tag, ".len"}, 64'(prog_len), 64'(e_len));
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0; host_wr_valid = 1'b0; host_wr_data = '0; host_wr_last = 1'b0;
    icache_rd_ctrl_en = 1'b0; icache_rd_ctrl_addr = '0;

    //   ls vld dat                     lst ren addr    rdy e_data                  fin ldd len
    add(0, 0, 54'h0,                    0, 1, 10'd0,   0, 54'h0,                   1, 0, 11'd0);
    add(1, 1, 54'hAA,                   0, 0, 10'd0,   0, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h1,                    0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h2,                    0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h20_0000_0000_0003,    1, 0, 10'd0,   1, 54'h0,                   0, 1, 11'd3);
    add(0, 0, 54'h0,                    0, 1, 10'd0,   0, 54'h1,                   0, 1, 11'd3);
    add(0, 0, 54'h0,                    0, 1, 10'd1,   0, 54'h2,                   0, 1, 11'd3);
    add(0, 0, 54'h0,                    0, 1, 10'd2,   0, 54'h20_0000_0000_0003,   0, 1, 11'd3);
    add(0, 1, 54'h77,                   0, 0, 10'd0,   0, 54'h20_0000_0000_0003,   0, 1, 11'd3);
    add(0, 0, 54'h0,                    0, 1, 10'd3,   0, 54'h0,                   1, 1, 11'd3);
    add(0, 0, 54'h0,                    0, 0, 10'd0,   0, 54'h0,                   1, 1, 11'd3);
    add(1, 1, 54'h55,                   0, 0, 10'd0,   0, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h11,                   0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 0, 54'h0,                    0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 0, 54'h0,                    0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h22,                   0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h33,                   0, 0, 10'd0,   1, 54'h0,                   0, 0, 11'd0);
    add(0, 1, 54'h44,                   1, 1, 10'd0,   1, 54'h0,                   1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'd0,   0, 54'h11,                  1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'd1,   0, 54'h22,                  1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'd2,   0, 54'h33,                  1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'd3,   0, 54'h44,                  1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'd4,   0, 54'h0,                   1, 1, 11'd4);
    add(0, 0, 54'h0,                    0, 1, 10'h3FF, 0, 54'h0,                   1, 1, 11'd4);

    #12 rst = 1'b0;
    #1;
    check("reset.ready", 64'(host_wr_ready), 64'd0);
    check_out("reset", '0, 1'b0, 1'b0, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ls, vecs[i].vld, vecs[i].dat, vecs[i].lst, vecs[i].ren, vecs[i].addr);
      #1;
      check($sformatf("vec%0d.ready", i), 64'(host_wr_ready), 64'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_fin, vecs[i].e_ldd, vecs[i].e_len);
    end

    // Fill every slot with no last: the load must stop at DEPTH without wrapping.
    drive(1, 0, '0, 0, 0, '0);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive(0, 1, fill_word(i), 0, 0, '0);
      if (i == DEPTH - 1) begin
        #1;
        check("fill.ready_last", 64'(host_wr_ready), 64'd1);
      end
    end
    @(posedge clk);
    #1;
    check("fill.len", 64'(prog_len), 64'd1024);
    check("fill.loaded", 64'(prog_loaded), 64'd1);
    drive(0, 1, 54'h3, 0, 0, '0);
    #1;
    check("fill.ready_after", 64'(host_wr_ready), 64'd0);
    drive(0, 0, '0, 0, 1, 10'd1023);
    @(posedge clk);
    #1;
    check_out("fill.rd1023", fill_word(1023), 1'b0, 1'b1, 11'd1024);
    drive(0, 0, '0, 0, 1, 10'd0);
    @(posedge clk);
    #1;
    check_out("fill.rd0", fill_word(0), 1'b0, 1'b1, 11'd1024);

`ifdef ICACHE_PARITY_EN
    check("par.clean", 64'(parity_err), 64'd0);
    dut.mem[1] = dut.mem[1] ^ 55'h1;
    drive(0, 0, '0, 0, 1, 10'd1);
    @(posedge clk);
    #1;
    check_out("par.corrupt", '0, 1'b1, 1'b1, 11'd1024);
    check("par.err", 64'(parity_err), 64'd1);
`endif

    // Asynchronous reset in the middle of a load.
    drive(1, 0, '0, 0, 0, '0);
    for (int unsigned i = 0; i < 5; i++) drive(0, 1, 54'(i + 100), 0, 0, '0);
    @(negedge clk);
    host_wr_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst.ready", 64'(host_wr_ready), 64'd0);
    check_out("rst", '0, 1'b0, 1'b0, '0);
`ifdef ICACHE_PARITY_EN
    check("rst.par_err", 64'(parity_err), 64'd0);
`endif
    #2 rst = 1'b0;
    drive(0, 0, '0, 0, 1, 10'd2);
    @(posedge clk);
    #1;
    check_out("rst.rd2", '0, 1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
